// File: rtl/morse_pkg.sv
// Shared constants for the Morse keyer: symbol codes, FSM state encoding and
// unit lengths of marks and gaps.
package morse_pkg;

    localparam logic [1:0] SYM_DOT  = 2'b00;
    localparam logic [1:0] SYM_DASH = 2'b01;
    localparam logic [1:0] SYM_LGAP = 2'b10;
    localparam logic [1:0] SYM_WGAP = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t MARK  = 2'd1;
    localparam state_t SPACE = 2'd2;

    localparam int unsigned DOT_UNITS      = 1;
    localparam int unsigned DASH_UNITS     = 3;
    localparam int unsigned ELEM_GAP_UNITS = 1;
    localparam int unsigned LGAP_EXTRA     = 2;
    localparam int unsigned WGAP_EXTRA     = 6;

    // Gap symbols add to the one-unit element gap already spent after a mark.
    function automatic logic [2:0] sym_units_m1(logic [1:0] code);
        logic [2:0] u;
        case (code)
            SYM_DOT:  u = 3'(DOT_UNITS - 1);
            SYM_DASH: u = 3'(DASH_UNITS - 1);
            SYM_LGAP: u = 3'(LGAP_EXTRA - 1);
            default:  u = 3'(WGAP_EXTRA - 1);
        endcase
        return u;
    endfunction

    function automatic state_t sym_state(logic [1:0] code);
        return code[1] ? SPACE : MARK;
    endfunction

endpackage

// File: rtl/morse_keyer_ctrl_if.sv
// Symbol handshake between the upstream symbol source and the keyer.
interface morse_keyer_ctrl_if;
    logic       sym_valid;
    logic [1:0] sym_code;
    logic       sym_ready;

    modport master (output sym_valid, output sym_code, input sym_ready);
    modport slave  (input sym_valid, input sym_code, output sym_ready);
endinterface

// File: rtl/morse_unit_timer.sv
// Prescaler counting clocks within one Morse unit; flags the last cycle of each unit.
module morse_unit_timer #(
    parameter int unsigned UNIT_CYCLES = 6000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic unit_last_o
);

    localparam int unsigned CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(UNIT_CYCLES - 1);

    logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;

    assign unit_last_o = (cyc_cnt_q == LAST);

    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        if (clr_i) begin
            cyc_cnt_d = '0;
        end else if (en_i) begin
            cyc_cnt_d = unit_last_o ? '0 : cyc_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

endmodule

// File: rtl/morse_keyer_ctrl.sv
// Morse keyer: expands handshaked symbols into timed key on/off intervals.
// Define MORSE_TONE_EN to add the gated sidetone output.
module morse_keyer_ctrl #(
    parameter int unsigned UNIT_CYCLES = 6000000
`ifdef MORSE_TONE_EN
    , parameter int unsigned TONE_HALF_CYCLES = 62500
`endif
) (
    input  logic               clk,
    input  logic               rst,
    morse_keyer_ctrl_if.slave  sym_if,
    output logic               key,
    output logic               busy
`ifdef MORSE_TONE_EN
    , output logic             tone
`endif
);
    import morse_pkg::*;

    state_t     state_q, state_d;
    logic [2:0] unit_cnt_q, unit_cnt_d;
    logic       key_q, key_d;
    logic       unit_last, ivl_last, xfer;

    morse_unit_timer #(
        .UNIT_CYCLES (UNIT_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .en_i        (state_q != IDLE),
        .clr_i       (xfer),
        .unit_last_o (unit_last)
    );

    assign ivl_last         = unit_last & (unit_cnt_q == 3'd0);
    assign sym_if.sym_ready = (state_q == IDLE) | ((state_q == SPACE) & ivl_last);
    assign xfer             = sym_if.sym_valid & sym_if.sym_ready;

    always_comb begin
        state_d    = state_q;
        unit_cnt_d = unit_cnt_q;
        if (xfer) begin
            state_d    = sym_state(sym_if.sym_code);
            unit_cnt_d = sym_units_m1(sym_if.sym_code);
        end else begin
            case (state_q)
                MARK: begin
                    if (ivl_last) begin
                        state_d    = SPACE;
                        unit_cnt_d = 3'(ELEM_GAP_UNITS - 1);
                    end else if (unit_last) begin
                        unit_cnt_d = unit_cnt_q - 3'd1;
                    end
                end
                SPACE: begin
                    if (ivl_last) begin
                        state_d = IDLE;
                    end else if (unit_last) begin
                        unit_cnt_d = unit_cnt_q - 3'd1;
                    end
                end
                default: ;
            endcase
        end
        key_d = (state_d == MARK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            unit_cnt_q <= 3'd0;
            key_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            unit_cnt_q <= unit_cnt_d;
            key_q      <= key_d;
        end
    end

    assign key  = key_q;
    assign busy = (state_q != IDLE);

`ifdef MORSE_TONE_EN
    localparam int unsigned TW = (TONE_HALF_CYCLES > 1) ? $clog2(TONE_HALF_CYCLES) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TONE_HALF_CYCLES - 1);

    logic [TW-1:0] tone_cnt_q, tone_cnt_d;
    logic          phase_q, phase_d;

    // Restart on key rise so every mark opens with a full low half-period.
    always_comb begin
        tone_cnt_d = tone_cnt_q + 1'b1;
        phase_d    = phase_q;
        if (key_d & ~key_q) begin
            tone_cnt_d = '0;
            phase_d    = 1'b0;
        end else if (tone_cnt_q == TLAST) begin
            tone_cnt_d = '0;
            phase_d    = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tone_cnt_q <= '0;
            phase_q    <= 1'b0;
        end else begin
            tone_cnt_q <= tone_cnt_d;
            phase_q    <= phase_d;
        end
    end

    assign tone = phase_q & key_q;
`endif

endmodule

// File: tb/tb_morse_keyer_ctrl.sv
// Scoreboard bench for morse_keyer_ctrl: per-cycle expected key/busy/ready(/tone) queued
// alongside the directed symbol stream, compared one cycle at a time after each edge.
module tb_morse_keyer_ctrl;
    import morse_pkg::*;

`ifdef MORSE_TONE_EN
    localparam int NI = 3;
`else
    localparam int NI = 2;
`endif

    typedef struct packed {
        logic k;
        logic b;
        logic r;
        logic t;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_v  [NI];
    logic       vld_v  [NI];
    logic [1:0] code_v [NI];
    logic       key0, busy0, key1, busy1;

    exp_t       eq[$];
    logic [1:0] sq[$];
    int         n_cmp  = 0;
    int         n_fail = 0;
    int         xfers  = 0;
    string      cur    = "init";

    always #5 clk = ~clk;

    morse_keyer_ctrl_if bus0 ();
    morse_keyer_ctrl_if bus1 ();
    assign bus0.sym_valid = vld_v[0];
    assign bus0.sym_code  = code_v[0];
    assign bus1.sym_valid = vld_v[1];
    assign bus1.sym_code  = code_v[1];

    morse_keyer_ctrl #(.UNIT_CYCLES(4)) u_dut4 (
        .clk    (clk),
        .rst    (rst_v[0]),
        .sym_if (bus0.slave),
        .key    (key0),
        .busy   (busy0)
`ifdef MORSE_TONE_EN
        , .tone ()
`endif
    );

    morse_keyer_ctrl #(.UNIT_CYCLES(1)) u_dut1 (
        .clk    (clk),
        .rst    (rst_v[1]),
        .sym_if (bus1.slave),
        .key    (key1),
        .busy   (busy1)
`ifdef MORSE_TONE_EN
        , .tone ()
`endif
    );

`ifdef MORSE_TONE_EN
    logic key2, busy2, tone2;
    morse_keyer_ctrl_if bus2 ();
    assign bus2.sym_valid = vld_v[2];
    assign bus2.sym_code  = code_v[2];

    morse_keyer_ctrl #(.UNIT_CYCLES(8), .TONE_HALF_CYCLES(2)) u_dut8 (
        .clk    (clk),
        .rst    (rst_v[2]),
        .sym_if (bus2.slave),
        .key    (key2),
        .busy   (busy2),
        .tone   (tone2)
    );
`endif

    function automatic exp_t sample(int s);
        exp_t o;
        case (s)
            0:       o = '{key0, busy0, bus0.sym_ready, 1'b0};
`ifdef MORSE_TONE_EN
            2:       o = '{key2, busy2, bus2.sym_ready, tone2};
`endif
            default: o = '{key1, busy1, bus1.sym_ready, 1'b0};
        endcase
        return o;
    endfunction

    task automatic chk(string tag, logic obs, logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s %s: observed %0b expected %0b", cur, tag, obs, exp);
        end
    endtask

    task automatic chk_n(string tag, int obs, int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s %s: observed %0d expected %0d", cur, tag, obs, exp);
        end
    endtask

    task automatic push(int n, logic k, logic b, logic r, logic t = 1'b0);
        for (int i = 0; i < n; i++) eq.push_back('{k, b, r, t});
    endtask

    // SPACE of n clocks: ready only on its final cycle.
    task automatic space(int n);
        push(n - 1, 1'b0, 1'b1, 1'b0);
        push(1, 1'b0, 1'b1, 1'b1);
    endtask

    // Consume the whole expectation queue, one clock per entry.
    task automatic run(int s);
        exp_t e, o;
        logic x;
        int   n;
        n = eq.size();
        for (int i = 0; i < n; i++) begin
            vld_v[s] = (sq.size() != 0);
            if (sq.size() != 0) code_v[s] = sq[0];
            o = sample(s);
            x = vld_v[s] & o.r & ~rst_v[s];
            @(posedge clk);
            #1;
            if (x) begin
                void'(sq.pop_front());
                xfers++;
            end
            e = eq.pop_front();
            o = sample(s);
            chk("key", o.k, e.k);
            chk("busy", o.b, e.b);
            chk("sym_ready", o.r, e.r);
            if (s == 2) chk("tone", o.t, e.t);
        end
        vld_v[s] = (sq.size() != 0);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst_v[i]  = 1'b1;
            vld_v[i]  = 1'b0;
            code_v[i] = 2'b00;
        end

        cur = "reset_u4";
        push(2, 1'b0, 1'b0, 1'b1);
        run(0);
        rst_v[0] = 1'b0;

        cur = "t1_dot";
        xfers = 0;
        push(5, 1'b0, 1'b0, 1'b1);
        run(0);
        sq.push_back(SYM_DOT);
        push(4, 1'b1, 1'b1, 1'b0);
        space(4);
        push(2, 1'b0, 1'b0, 1'b1);
        run(0);
        chk_n("xfers", xfers, 1);

        cur = "t2_dash_dot";
        xfers = 0;
        sq.push_back(SYM_DASH);
        sq.push_back(SYM_DOT);
        push(12, 1'b1, 1'b1, 1'b0);
        space(4);
        push(4, 1'b1, 1'b1, 1'b0);
        space(4);
        push(2, 1'b0, 1'b0, 1'b1);
        run(0);
        chk_n("xfers", xfers, 2);

        cur = "t3_letter_gap";
        xfers = 0;
        sq.push_back(SYM_DOT);
        sq.push_back(SYM_LGAP);
        sq.push_back(SYM_DOT);
        push(4, 1'b1, 1'b1, 1'b0);
        space(4);
        space(8);
        push(4, 1'b1, 1'b1, 1'b0);
        space(4);
        push(2, 1'b0, 1'b0, 1'b1);
        run(0);
        chk_n("xfers", xfers, 3);

        cur = "t3_word_gap";
        xfers = 0;
        sq.push_back(SYM_DOT);
        sq.push_back(SYM_WGAP);
        sq.push_back(SYM_DOT);
        push(4, 1'b1, 1'b1, 1'b0);
        space(4);
        space(24);
        push(4, 1'b1, 1'b1, 1'b0);
        space(4);
        push(2, 1'b0, 1'b0, 1'b1);
        run(0);
        chk_n("xfers", xfers, 3);

        cur = "t5_reset_mid_dash";
        xfers = 0;
        sq.push_back(SYM_DASH);
        push(3, 1'b1, 1'b1, 1'b0);
        run(0);
        rst_v[0] = 1'b1;
        sq.push_back(SYM_DOT);
        push(1, 1'b0, 1'b0, 1'b1);
        run(0);
        rst_v[0] = 1'b0;
        push(4, 1'b1, 1'b1, 1'b0);
        space(4);
        push(2, 1'b0, 1'b0, 1'b1);
        run(0);
        chk_n("xfers", xfers, 2);

        cur = "t5_reset_with_valid";
        xfers = 0;
        rst_v[0] = 1'b1;
        sq.push_back(SYM_DOT);
        push(2, 1'b0, 1'b0, 1'b1);
        run(0);
        rst_v[0] = 1'b0;
        push(4, 1'b1, 1'b1, 1'b0);
        space(4);
        push(2, 1'b0, 1'b0, 1'b1);
        run(0);
        chk_n("xfers", xfers, 1);

        cur = "reset_u1";
        push(2, 1'b0, 1'b0, 1'b1);
        run(1);
        rst_v[1] = 1'b0;

        cur = "t4_u1_dot_stream";
        xfers = 0;
        for (int i = 0; i < 8; i++) begin
            sq.push_back(SYM_DOT);
            push(1, 1'b1, 1'b1, 1'b0);
            push(1, 1'b0, 1'b1, 1'b1);
        end
        push(2, 1'b0, 1'b0, 1'b1);
        run(1);
        chk_n("xfers", xfers, 8);

`ifdef MORSE_TONE_EN
        cur = "reset_u8";
        push(2, 1'b0, 1'b0, 1'b1, 1'b0);
        run(2);
        rst_v[2] = 1'b0;

        cur = "t6_tone";
        xfers = 0;
        sq.push_back(SYM_DOT);
        for (int i = 0; i < 8; i++) push(1, 1'b1, 1'b1, 1'b0, ((i >> 1) & 1) == 1);
        space(8);
        push(2, 1'b0, 1'b0, 1'b1, 1'b0);
        run(2);
        chk_n("xfers", xfers, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/morse_keyer_ctrl.md
Name: morse_keyer_ctrl

Overview:
Sequences the beacon's Morse symbol stream into a timed on/off key signal.
- Accepts 2-bit symbol codes from an upstream source (message ROM walker or bit generator) over a valid/ready handshake.
- Expands each symbol into mark/space intervals measured in integer "units" of UNIT_CYCLES clocks.
- Drives the transmitter key line in the 100 MHz beacon datapath.

Parameters:
UNIT_CYCLES, 6000000, clocks per Morse unit (20 wpm at 100 MHz); legal range >=1.
TONE_HALF_CYCLES, 62500, half-period of sidetone in clocks (800 Hz at 100 MHz); used only with MORSE_TONE_EN.

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous reset, active-high
sym_valid  in  1  upstream has a symbol on sym_code
sym_code  in  2  00 DOT, 01 DASH, 10 LETTER_GAP, 11 WORD_GAP
sym_ready  out  1  controller accepts sym_code this cycle
key  out  1  keyed carrier enable, registered
busy  out  1  high whenever state != IDLE
tone  out  1  gated sidetone square wave (MORSE_TONE_EN only)

Behaviour:
- Reset values: key=0, busy=0, tone=0, sym_ready=1 (combinational, IDLE). Unit counter and cycle counter are 0. Reset mid-symbol aborts at the next edge: key=0 and state=IDLE on the following cycle.
- Counters:
  - cyc_cnt counts 0..UNIT_CYCLES-1. Width is clog2(UNIT_CYCLES), minimum 1.
  - unit_cnt is 3 bits and holds remaining units of the current interval, minus 1.
- States: IDLE, MARK, SPACE.
- Handshake: transfer happens when sym_valid & sym_ready. sym_ready = (state==IDLE) | (state==SPACE & last cycle of SPACE). Upstream may hold sym_valid low indefinitely; sym_code is sampled only on transfer.
- Transfer actions (next cycle):
  - DOT: MARK for 1 unit.
  - DASH: MARK for 3 units.
  - LETTER_GAP: SPACE for 2 units.
  - WORD_GAP: SPACE for 6 units.
- MARK: key=1. At the end of its last unit, enter SPACE for exactly 1 unit (inter-element gap).
- Gap totals: an element followed by LETTER_GAP gives 3 units off; an element followed by WORD_GAP gives 7 units off.
- SPACE end:
  - Transfer on the last cycle: go directly to the new symbol's state, with no idle bubble.
  - No transfer: go to IDLE.
- Latency: key rises exactly 1 cycle after a DOT/DASH transfer. MARK durations are exact: DOT = UNIT_CYCLES clocks, DASH = 3*UNIT_CYCLES clocks.
- Throughput: a continuous DOT stream gives a key period of exactly 2*UNIT_CYCLES.
- key is a registered output, asserted from the MARK state register with no combinational path from inputs.
- busy=1 in MARK and SPACE, including the handoff cycle.
- Simultaneous rst and sym_valid: rst wins; no symbol is consumed.
- UNIT_CYCLES=1: every cycle is a "last cycle". Timing rules above still hold exactly.

Optional Feature:
MORSE_TONE_EN
- Defined: adds the tone port and a free-running half-period counter (0..TONE_HALF_CYCLES-1) that toggles a phase bit at wrap.
  - tone = phase & key.
  - The counter and phase reset to 0 on rst, and restart from 0 on each key rising edge so every mark starts with a full low half-period.
- Undefined: no tone port, no tone counter; all other behaviour is identical.

Decomposition:
- Package morse_pkg:
  - symbol code localparams SYM_DOT/SYM_DASH/SYM_LGAP/SYM_WGAP;
  - state enum IDLE/MARK/SPACE;
  - unit-length constants DOT_UNITS=1, DASH_UNITS=3, ELEM_GAP_UNITS=1, LGAP_EXTRA=2, WGAP_EXTRA=6.
- One sub-module, morse_unit_timer:
  - cyc_cnt prescaler with load/clear, producing unit_last (last cycle of a unit);
  - parameterised by UNIT_CYCLES.
  - The FSM and unit_cnt stay in morse_keyer_ctrl.

Test Plan:
1. UNIT_CYCLES=4, single DOT at cycle 10 → key=1 cycles 11-14, key=0 cycles 15-18, sym_ready=1 at cycle 18, busy=0 from cycle 19.
2. UNIT_CYCLES=4, DASH then DOT back-to-back with valid held high → key high 12 clocks, low 4, high 4, low 4; second transfer occurs on the last SPACE cycle; no idle gap.
3. UNIT_CYCLES=4, DOT, LETTER_GAP, DOT → key-off gap between marks is exactly 12 clocks; with WORD_GAP instead, exactly 28 clocks.
4. UNIT_CYCLES=1, DOT stream of 8 symbols → key toggles every cycle (1010...), sym_ready high every second cycle, 8 transfers in 16 cycles.
5. rst asserted at cycle 3 of a DASH mark → key=0 and busy=0 on the next cycle; sym_ready=1; a subsequent DOT times correctly from scratch.
6. MORSE_TONE_EN, TONE_HALF_CYCLES=2, UNIT_CYCLES=8, DOT → tone pattern 0,0,1,1,0,0,1,1 during the mark, 0 throughout the space.
